// File: rtl/dec_ser_out.sv
// dec_ser_out: buffers decimated samples in a small FIFO and shifts each one
// out MSB-first on a three-wire link (bit clock, data, frame).
module dec_ser_out #(
  parameter int DATA_W     = 22,
  parameter int FIFO_DEPTH = 4,
  parameter int HALF_DIV   = 2,
  parameter int GAP_CYC    = 4
) (
  input  logic                          clk_fs,
  input  logic                          rst_b,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          valid_strobe,
  input  logic                          en,
  input  logic                          clr_ovf,
  output logic                          ser_clk,
  output logic                          ser_data,
  output logic                          ser_frame,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PH_W  = $clog2(HALF_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int SH_W  = DATA_W - 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;

  state_t            state_q;
  logic [SH_W-1:0]   shreg_q;
  logic [PH_W-1:0]   phase_q;
  logic [BIT_W-1:0]  bit_q;
  logic [GAP_W-1:0]  gap_q;
  logic              ser_clk_q, ser_data_q, ser_frame_q;

  logic full, pop, push, drop;

  // A word leaves the FIFO exactly when the FSM starts a frame; a push is
  // still accepted on a full FIFO if that same cycle frees a slot.
  assign full = (level_q == LVL_FULL);
  assign pop  = (state_q == IDLE) && en && (level_q != '0);
  assign push = valid_strobe && (!full || pop);
  assign drop = valid_strobe && full && !pop;

  // Next FIFO occupancy and sticky overflow (a drop beats a simultaneous clear).
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Sample storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk_fs) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  // FIFO pointers, occupancy and overflow flag; pointers wrap naturally.
  always_ff @(posedge clk_fs or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Serializer FSM: load a word, emit low/high bit-clock phases, then idle gap.
  always_ff @(posedge clk_fs or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      phase_q     <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_frame_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shreg_q     <= mem_q[rd_ptr_q][SH_W-1:0];
            ser_data_q  <= mem_q[rd_ptr_q][DATA_W-1];
            ser_frame_q <= 1'b1;
            ser_clk_q   <= 1'b0;
            phase_q     <= '0;
            bit_q       <= '0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (phase_q == PH_LAST) begin
            phase_q <= '0;
            if (!ser_clk_q) begin
              ser_clk_q <= 1'b1;
            end else begin
              ser_clk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                ser_frame_q <= 1'b0;
                ser_data_q  <= 1'b0;
                gap_q       <= '0;
                state_q     <= GAP;
              end else begin
                ser_data_q <= shreg_q[SH_W-1];
                shreg_q    <= shreg_q << 1;
                bit_q      <= bit_q + BIT_W'(1);
              end
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ser_clk    = ser_clk_q;
  assign ser_data   = ser_data_q;
  assign ser_frame  = ser_frame_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule
